// File: rtl/mcs4_ram_array.sv
// Parametrised i4002 RAM array: N_BANK x N_CHIP chips snooping the MCS-4 bus.
// Define MCS4_RAM_CLEAR_EN to add the post-reset array clear sequencer.
module mcs4_ram_array #(
    parameter int         N_BANK    = 8,
    parameter int         N_CHIP    = 4,
    parameter logic [3:0] CHIP_MASK = 4'b1111
) (
    input  logic                       CLK,
    input  logic                       RES_N,
    input  logic                       SYNC_N,
    input  logic [3:0]                 DATA_I,
    output logic [3:0]                 DATA_O,
    output logic                       DATA_OE,
    input  logic [N_BANK-1:0]          CM_N,
    output logic [N_BANK*N_CHIP*4-1:0] PORT_OUT,
    output logic                       INIT_BUSY
);

    localparam int NMAIN = N_BANK * N_CHIP * 64;
    localparam int MW    = $clog2(NMAIN);
    localparam int SW    = MW - 2;
    localparam int BW    = (N_BANK > 1) ? $clog2(N_BANK) : 1;

    typedef enum logic [7:0] {
        ST_STOP = 8'h00,
        ST_A1   = 8'h01,
        ST_A2   = 8'h02,
        ST_A3   = 8'h04,
        ST_M1   = 8'h08,
        ST_M2   = 8'h10,
        ST_X1   = 8'h20,
        ST_X2   = 8'h40,
        ST_X3   = 8'h80
    } cyc_t;

    cyc_t                       state_q, state_d;
    logic [7:0]                 src_q, src_d;
    logic                       src_pend_q, src_pend_d;
    logic [4:0]                 opa_q, opa_d;
    logic [BW-1:0]              bank_q, bank_d;
    logic                       cm_hit;
    logic [N_BANK*N_CHIP*4-1:0] port_q;
    logic [3:0]                 main_mem [NMAIN];
    logic [3:0]                 stat_mem [NMAIN/4];
    logic [3:0]                 rd_q;

    logic                       busy, clr_we, clr_stat;
    logic [MW-1:0]              clr_addr;

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        cm_hit     = 1'b0;
        src_d      = src_q;
        src_pend_d = src_pend_q;
        opa_d      = opa_q;
        if (!SYNC_N) begin
            state_d = ST_A1;
        end else begin
            case (state_q)
                ST_A1:   state_d = ST_A2;
                ST_A2:   state_d = ST_A3;
                ST_A3:   state_d = ST_M1;
                ST_M1:   state_d = ST_M2;
                ST_M2:   state_d = ST_X1;
                ST_X1:   state_d = ST_X2;
                ST_X2:   state_d = ST_X3;
                default: state_d = ST_STOP;
            endcase
        end
        // Lowest-numbered active CM line selects the bank.
        for (int unsigned i = 0; i < N_BANK; i++) begin
            if (!CM_N[i] && !cm_hit) begin
                bank_d = BW'(i);
                cm_hit = 1'b1;
            end
        end
        if (state_q == ST_X2 && cm_hit) begin
            src_d[7:4] = DATA_I;
            src_pend_d = 1'b1;
        end
        if (state_q == ST_X3 && src_pend_q) begin
            src_d[3:0] = DATA_I;
            src_pend_d = 1'b0;
        end
        if (state_q == ST_M2 && cm_hit) begin
            opa_d = {1'b1, DATA_I};
        end else if (state_q == ST_X3) begin
            opa_d = '0;
        end
    end

    logic [1:0]    chip;
    int            unit_idx;
    logic          sel, act;
    logic [MW-1:0] main_addr;
    logic [SW-1:0] stat_addr;
    logic          is_wrm, is_wmp, is_wrs, is_rdm, is_rds;
    logic          we_main, we_stat, we_port;

    assign chip      = src_q[7:6];
    assign unit_idx  = int'(bank_q) * N_CHIP + int'(chip);
    assign sel       = (int'(chip) < N_CHIP) && CHIP_MASK[chip] && (int'(bank_q) < N_BANK);
    assign act       = sel && !busy;
    assign main_addr = MW'(unit_idx * 64 + int'(src_q[5:0]));
    assign stat_addr = SW'(unit_idx * 16 + int'({src_q[5:4], opa_q[1:0]}));

    assign is_wrm = (opa_q == 5'b10000);
    assign is_wmp = (opa_q == 5'b10001);
    assign is_wrs = (opa_q[4:2] == 3'b101);
    assign is_rdm = (opa_q inside {5'b11000, 5'b11001, 5'b11011});
    assign is_rds = (opa_q[4:2] == 3'b111);

    assign we_main = (state_q == ST_X2) && act && is_wrm;
    assign we_stat = (state_q == ST_X2) && act && is_wrs;
    assign we_port = (state_q == ST_X2) && act && is_wmp;

    assign DATA_OE   = (state_q == ST_X2) && act && (is_rdm || is_rds);
    assign DATA_O    = DATA_OE ? rd_q : '0;
    assign PORT_OUT  = port_q;
    assign INIT_BUSY = busy;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q    <= ST_STOP;
            src_q      <= '0;
            src_pend_q <= 1'b0;
            opa_q      <= '0;
            bank_q     <= '0;
            port_q     <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            src_pend_q <= src_pend_d;
            opa_q      <= opa_d;
            bank_q     <= bank_d;
            if (we_port) port_q[unit_idx*4 +: 4] <= DATA_I;
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            main_mem[clr_addr] <= '0;
            if (clr_stat) stat_mem[clr_addr[SW-1:0]] <= '0;
        end
        if (we_main) main_mem[main_addr] <= DATA_I;
        if (we_stat) stat_mem[stat_addr] <= DATA_I;
        if (state_q == ST_X1 && sel) rd_q <= is_rds ? stat_mem[stat_addr] : main_mem[main_addr];
    end

`ifdef MCS4_RAM_CLEAR_EN
    typedef enum logic {CL_CLEAR, CL_READY} clr_t;

    clr_t          clr_st_q, clr_st_d;
    logic [MW-1:0] clr_q, clr_d;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            clr_st_q <= CL_CLEAR;
            clr_q    <= '0;
        end else begin
            clr_st_q <= clr_st_d;
            clr_q    <= clr_d;
        end
    end

    always_comb begin
        clr_st_d = clr_st_q;
        clr_d    = clr_q;
        if (clr_st_q == CL_CLEAR) begin
            clr_d = clr_q + 1'b1;
            if (clr_q == MW'(NMAIN - 1)) clr_st_d = CL_READY;
        end
    end

    // Status sweep shares the counter and finishes after the first quarter.
    assign busy     = (clr_st_q == CL_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_q;
    assign clr_stat = (clr_q < MW'(NMAIN / 4));
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
    assign clr_stat = 1'b0;
`endif

endmodule

// File: doc/mcs4_ram_array.md
Name: mcs4_ram_array

Overview:
Parametrised i4002 RAM array model for the MCS-4 system: N_BANK banks x N_CHIP chips per bank, each chip holding 64 main characters, 16 status characters and one 4-bit output port. It snoops the CPU bus (SYNC_N, DATA_I, CM_N), decodes SRC, I/O and RAM instructions, and drives DATA_O/DATA_OE for reads. New over the fixed 8x4 model: configurable geometry, a chip-population mask (absent chips never respond) and an optional post-reset clear sequencer.

Parameters:
N_BANK, 8, banks (1..8); width of CM_N.
N_CHIP, 4, chips per bank (1..4).
CHIP_MASK, 4'b1111, bit c=1 means chip c is populated in every bank; bits >= N_CHIP ignored.

Ports:
CLK  in  1  clock.
RES_N  in  1  reset; asynchronous, active-low.
SYNC_N  in  1  CPU sync; low during X3 marks the next cycle as A1.
DATA_I  in  4  CPU data bus in.
DATA_O  out  4  data bus out; 0 when DATA_OE=0.
DATA_OE  out  1  data bus drive enable.
CM_N  in  N_BANK  RAM command lines, active-low, one per bank.
PORT_OUT  out  N_BANK*N_CHIP*4  output ports; nibble [(b*N_CHIP+c)*4 +: 4] = bank b, chip c.
INIT_BUSY  out  1  clear sequencer running.

Behaviour:
- Reset: state=0 (stopped), src=0, opa=0, bank=0, all PORT_OUT=0, DATA_OE=0, DATA_O=0. INIT_BUSY per Optional Feature.
- Cycle state: one-hot A1,A2,A3,M1,M2,X1,X2,X3. SYNC_N=0 -> A1 next. Otherwise rotate. At X3 with SYNC_N=1 -> stopped (all zero) until next SYNC_N=0.
- Bank latch: every cycle, if any CM_N bit low, bank <= index of lowest low bit; else hold.
- SRC: at X2 with any CM_N low -> src[7:4] <= DATA_I, set src_pending. At X3 with src_pending -> src[3:0] <= DATA_I, clear src_pending.
- OPA: at M2 with any CM_N low -> opa <= {1,DATA_I}. Cleared at X3.
- Chip select: chip = src[7:6], register = src[5:4], char = src[3:0]. Selected iff chip < N_CHIP and CHIP_MASK[chip]=1 and bank < N_BANK. Unselected: no write, no drive, port unchanged.
- Main char address = {bank, src}; status address = {bank, src[7:4], opa[1:0]}.
- Writes at X2, data DATA_I: WRM (opa 1_0000) -> main; WR0-3 (1_01xx) -> status; WMP (1_0001) -> PORT_OUT[bank][chip].
- Reads: memory read registered at X1 (1-cycle array latency); DATA_OE=1 and DATA_O=read data during X2 only for SBM 1_1000, RDM 1_1001, ADM 1_1011 (main) and RD0-3 1_11xx (status).
- WRR, WPM, RDR, opa=0 (non-I/O): ignored; DATA_OE stays 0.
- Multiple CM_N low: lowest index wins; only that bank acts.
- While INIT_BUSY=1: state/src/opa/bank tracking continues; all writes suppressed, DATA_OE forced 0.
- RES_N low mid-cycle or mid-sweep: everything returns to reset values immediately; sweep restarts on release.

Optional Feature:
MCS4_RAM_CLEAR_EN. Defined: FSM CLEAR->READY. After RES_N rises, INIT_BUSY=1 and a counter writes 0 to main addresses 0..N_BANK*N_CHIP*64-1 and status addresses 0..N_BANK*N_CHIP*16-1, one of each per cycle in parallel. INIT_BUSY drops the cycle after the last main write, i.e. it is high for exactly N_BANK*N_CHIP*64 cycles. Undefined: no sequencer, INIT_BUSY tied 0, array contents uninitialised (X in simulation).

Test Plan:
- Defaults, CLEAR_EN: release reset -> INIT_BUSY high 2048 cycles; then RDM at bank0 src 0x00 -> DATA_O=0, DATA_OE=1 only during X2.
- SRC 0x5A via CM_N[3] low, then WRM with DATA_I=0x7; RDM at same SRC/bank -> DATA_O=0x7 at X2; RDM bank 2 same SRC -> 0 (CLEAR_EN).
- WR2 data 0xC at bank1 src 0x90, then RD2 -> 0xC; RD1 -> 0; main char 0x90 unaffected.
- WMP data 0xE, bank 5, src 0xC0 -> PORT_OUT nibble (5*4+3) = 0xE, all others unchanged.
- N_CHIP=2, CHIP_MASK=2'b01: RDM with src 0x40 or 0xC0 -> DATA_OE never asserted; WMP to chip 1 -> PORT_OUT unchanged.
- No SYNC_N at X3 -> state stops, DATA_OE stays 0. CM_N=8'b1111_0101 -> bank 1 selected. RES_N pulse during sweep -> INIT_BUSY restarts full count.
